// File: rtl/ysyx_041461_axi_pkg.sv
// ysyx_041461_axi_pkg: shared AXI burst/response encodings, crossbar master IDs and read-slave state type
package ysyx_041461_axi_pkg;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [3:0] IF_AXI_id = 4'b0000, MEM_AXI_id = 4'b0001;
  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
endpackage

// File: rtl/ysyx_041461_axi_sram_rd_slave_if.sv
// ysyx_041461_axi_sram_rd_slave_if: AXI4 AR/R channel bundle between the read crossbar and the SRAM slave
interface ysyx_041461_axi_sram_rd_slave_if;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  modport master(output arvalid, araddr, arid, arlen, arsize, arburst, rready,
                 input arready, rvalid, rdata, rresp, rlast, rid);
  modport slave(input arvalid, araddr, arid, arlen, arsize, arburst, rready,
                output arready, rvalid, rdata, rresp, rlast, rid);
endinterface

// File: rtl/ysyx_041461_axi_burst_next.sv
// ysyx_041461_axi_burst_next: next beat address for FIXED/INCR/WRAP bursts and burst legality flag
module ysyx_041461_axi_burst_next
  import ysyx_041461_axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  arsize,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic [31:0] next_addr,
  output logic        legal
);
  logic [31:0] size, mask;
  assign size = 32'd1 << arsize;
  assign mask = ((32'(arlen) + 32'd1) << arsize) - 32'd1;
  assign next_addr = arburst == INCR ? addr + size :
                     arburst == WRAP ? (addr & ~mask) | ((addr + size) & mask) : addr;
  assign legal = arburst != RSVD && !arsize[2] &&
                 (arburst != WRAP || arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
endmodule

// File: rtl/ysyx_041461_axi_sram_rd_slave.sv
// ysyx_041461_axi_sram_rd_slave: AXI4 read-only SRAM slave with optional first-beat latency
module ysyx_041461_axi_sram_rd_slave
  import ysyx_041461_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter              INIT_FILE   = "",
  parameter int          LATENCY     = 2
) (
  input logic clk,
  input logic rst,
  ysyx_041461_axi_sram_rd_slave_if.slave s
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(8 * DEPTH_WORDS);
  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || LATENCY < 0 || LATENCY > 256) begin : g_bad_cfg
    $error("DEPTH_WORDS must be a power of 2 and LATENCY within 0..256");
  end
  logic [63:0] mem [DEPTH_WORDS];
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end
  state_t state, state_n;
  logic [31:0] addr, nxt, ba, boff;
  logic [7:0] len, cnt;
  logic [2:0] size;
  logic [1:0] burst, rresp_q;
  logic [3:0] id;
  logic [63:0] rdata_q, bdata;
  logic idle, legal, legal_q, bl, bok, arready_q, ar_hs, r_hs, rlast_q;
  assign idle = state == IDLE;
  assign ar_hs = s.arvalid && arready_q;
  assign r_hs = state == DATA && s.rready;
  ysyx_041461_axi_burst_next u_next (
    .addr(idle ? s.araddr : addr), .arsize(idle ? s.arsize : size),
    .arlen(idle ? s.arlen : len), .arburst(idle ? s.arburst : burst),
    .next_addr(nxt), .legal(legal)
  );
  always_comb begin
    ba = idle ? s.araddr : nxt;
    bl = idle ? legal : legal_q;
    boff = ba - BASE_ADDR;
    bok = bl && ba >= BASE_ADDR && boff < SPAN;
    bdata = bok ? mem[boff[AW+2:3]] : '0;
  end
`ifdef AXI_SRAM_LATENCY_EN
  localparam state_t FIRST = LATENCY == 0 ? DATA : WAIT;
  logic [7:0] lat;
  always_ff @(posedge clk)
    lat <= rst ? '0 : ar_hs ? 8'(LATENCY - 1) : state == WAIT ? lat - 8'd1 : lat;
`else
  localparam state_t FIRST = DATA;
`endif
  always_comb begin
    state_n = state;
    if (idle && ar_hs) state_n = FIRST;
    if (r_hs && rlast_q) state_n = IDLE;
`ifdef AXI_SRAM_LATENCY_EN
    if (state == WAIT && lat == 8'd0) state_n = DATA;
`endif
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    arready_q <= !rst && state_n == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {addr, len, cnt, size, burst, legal_q, id, rdata_q, rresp_q, rlast_q} <= '0;
    end else if (ar_hs || (r_hs && !rlast_q)) begin
      addr <= ba;
      cnt <= ar_hs ? 8'd0 : cnt + 8'd1;
      rdata_q <= bdata;
      rresp_q <= bok ? OKAY : SLVERR;
      rlast_q <= ar_hs ? s.arlen == 8'd0 : cnt + 8'd1 == len;
      if (ar_hs) begin
        id <= s.arid;
        len <= s.arlen;
        size <= s.arsize;
        burst <= s.arburst;
        legal_q <= legal;
      end
    end
  end
  assign s.arready = arready_q;
  assign s.rvalid = state == DATA;
  assign s.rdata = rdata_q;
  assign s.rresp = rresp_q;
  assign s.rlast = rlast_q;
  assign s.rid = id;
endmodule

// File: tb/tb_ysyx_041461_axi_sram_rd_slave.sv
// tb_ysyx_041461_axi_sram_rd_slave: table-driven and random bursts against a burst-level reference model
module tb_ysyx_041461_axi_sram_rd_slave;
  import ysyx_041461_axi_pkg::*;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 4096;
  localparam int EXP_LAT = `ifdef AXI_SRAM_LATENCY_EN 3 `else 1 `endif;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  ysyx_041461_axi_sram_rd_slave_if ifc();
  ysyx_041461_axi_sram_rd_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE(""), .LATENCY(2))
    dut (.clk(clk), .rst(rst), .s(ifc));
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] rdy;
    logic [1:0]  r0;
  } vec_t;
  int checks = 0, errors = 0;
  logic [63:0] m [DEPTH];
  vec_t tbl [12];
  vec_t v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_addr(vec_t x, int i);
    logic [31:0] sz, b, base;
    sz = 32'd1 << x.size;
    b = (32'(x.len) + 32'd1) * sz;
    base = x.addr & ~(b - 32'd1);
    if (x.burst == INCR) return x.addr + 32'(i) * sz;
    if (x.burst == WRAP) return base + (x.addr - base + 32'(i) * sz) % b;
    return x.addr;
  endfunction

  function automatic bit legal_burst(vec_t x);
    return x.burst != RSVD && x.size <= 3 && (x.burst != WRAP || x.len inside {1, 3, 7, 15});
  endfunction

  function automatic bit in_range(logic [31:0] a);
    return a >= BASE && 64'(a) < 64'(BASE) + 64'(8 * DEPTH);
  endfunction

  task automatic ar_issue(input vec_t x);
    int t = 0;
    ifc.arid = x.id; ifc.araddr = x.addr; ifc.arlen = x.len;
    ifc.arsize = x.size; ifc.arburst = x.burst; ifc.arvalid = 1;
    while (!ifc.arready && t < 100) begin @(negedge clk); t++; end
    chk("ar_accept", 64'(t < 100), 64'd1);
    @(negedge clk);
    ifc.arvalid = 0;
  endtask

  task automatic do_burst(input vec_t x);
    int lat = 1, i = 0, cyc = 0;
    logic [31:0] a;
    bit ok;
    ar_issue(x);
    while (!ifc.rvalid && lat < 20) begin
      chk("arready_wait", 64'(ifc.arready), 64'd0);
      @(negedge clk); lat++;
    end
    chk("first_latency", 64'(lat), 64'(EXP_LAT));
    while (i <= int'(x.len) && cyc < 800) begin
      ifc.rready = x.rdy[cyc % 32];
      a = beat_addr(x, i);
      ok = legal_burst(x) && in_range(a);
      chk("rvalid", 64'(ifc.rvalid), 64'd1);
      chk("arready_busy", 64'(ifc.arready), 64'd0);
      chk("rid", 64'(ifc.rid), 64'(x.id));
      chk("rresp", 64'(ifc.rresp), ok ? 64'(OKAY) : 64'(SLVERR));
      chk("rlast", 64'(ifc.rlast), 64'(i == int'(x.len)));
      if (ok) chk("rdata", ifc.rdata, m[(a - BASE) >> 3]);
      else if (!in_range(a)) chk("rdata_oor", ifc.rdata, 64'd0);
      if (i == 0) chk("tbl_resp0", 64'(ifc.rresp), 64'(x.r0));
      if (ifc.rready) i++;
      @(negedge clk); cyc++;
    end
    ifc.rready = 0;
    chk("beats", 64'(i), 64'(x.len) + 64'd1);
    chk("rvalid_end", 64'(ifc.rvalid), 64'd0);
    chk("arready_end", 64'(ifc.arready), 64'd1);
  endtask

  initial begin
    tbl[0]  = '{4'd1, 32'h8000_0010, 8'd3, 3'd3, INCR,  32'hFFFF_FFFF, OKAY};
    tbl[1]  = '{4'd0, 32'h8000_0018, 8'd3, 3'd3, WRAP,  32'hFFFF_FFFF, OKAY};
    tbl[2]  = '{4'd0, 32'h8000_0018, 8'd2, 3'd3, WRAP,  32'hFFFF_FFFF, SLVERR};
    tbl[3]  = '{4'd1, 32'h8000_0000, 8'd2, 3'd3, FIXED, 32'h0000_0019, OKAY};
    tbl[4]  = '{4'd0, 32'h7FFF_FFF8, 8'd0, 3'd3, INCR,  32'hFFFF_FFFF, SLVERR};
    tbl[5]  = '{IF_AXI_id,  32'h8000_0100, 8'd1, 3'd3, INCR, 32'hFFFF_FFFF, OKAY};
    tbl[6]  = '{MEM_AXI_id, 32'h8000_0200, 8'd2, 3'd3, INCR, 32'hFFFF_FFFF, OKAY};
    tbl[7]  = '{4'd2, 32'h8000_7FF8, 8'd1, 3'd3, INCR,  32'hFFFF_FFFF, OKAY};
    tbl[8]  = '{4'd3, 32'h8000_0020, 8'd3, 3'd2, INCR,  32'hAAAA_AAAB, OKAY};
    tbl[9]  = '{4'd4, 32'h8000_0040, 8'd1, 3'd3, RSVD,  32'hFFFF_FFFF, SLVERR};
    tbl[10] = '{4'd5, 32'h8000_0040, 8'd0, 3'd4, INCR,  32'hFFFF_FFFF, SLVERR};
    tbl[11] = '{4'd6, 32'h8000_0050, 8'd7, 3'd1, WRAP,  32'h5555_5555, OKAY};
    ifc.arvalid = 0; ifc.araddr = 0; ifc.arid = 0; ifc.arlen = 0;
    ifc.arsize = 0; ifc.arburst = 0; ifc.rready = 0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = {$urandom(), $urandom()};
      dut.mem[i] = m[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(ifc.arready), 64'd0);
    chk("rst_rvalid", 64'(ifc.rvalid), 64'd0);
    chk("rst_rlast", 64'(ifc.rlast), 64'd0);
    chk("rst_rresp", 64'(ifc.rresp), 64'd0);
    chk("rst_rid", 64'(ifc.rid), 64'd0);
    chk("rst_rdata", ifc.rdata, 64'd0);
    rst = 0;
    @(negedge clk);
    chk("arready_after_rst", 64'(ifc.arready), 64'd1);
    foreach (tbl[k]) do_burst(tbl[k]);
    for (int k = 0; k < 30; k++) begin
      v.id = 4'($urandom());
      v.addr = BASE - 32'd64 + 32'($urandom_range(0, 8 * DEPTH + 128));
      v.len = ($urandom() % 3 == 0) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 19));
      v.size = 3'($urandom_range(0, 4));
      v.burst = 2'($urandom());
      v.rdy = $urandom() | 32'd1;
      v.r0 = legal_burst(v) && in_range(v.addr) ? OKAY : SLVERR;
      do_burst(v);
    end
    v = '{4'd7, 32'h8000_0000, 8'd7, 3'd3, INCR, 32'hFFFF_FFFF, OKAY};
    ar_issue(v);
    ifc.rready = 1;
    for (int t = 0; t < 20 && !ifc.rvalid; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("midburst_rvalid", 64'(ifc.rvalid), 64'd1);
    rst = 1;
    @(negedge clk);
    chk("abort_rvalid", 64'(ifc.rvalid), 64'd0);
    chk("abort_arready", 64'(ifc.arready), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("abort_arready_up", 64'(ifc.arready), 64'd1);
    chk("abort_no_beat", 64'(ifc.rvalid), 64'd0);
    @(negedge clk);
    chk("abort_no_beat2", 64'(ifc.rvalid), 64'd0);
    ifc.rready = 0;
    do_burst(tbl[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
